pos_mask_decoder: RTL and testbench

POS_MASK_DECODER -- requirements
Module: pos_mask_decoder

---
 rtl/pos_dec_pkg.sv | 16 +
 rtl/pos_onehot_dec.sv | 15 +
 rtl/pos_mask_decoder.sv | 98 +++++++++
 tb/tb_pos_mask_decoder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pos_dec_pkg.sv
// Shared definitions for the position-mask decoder: FSM state encoding
// and the default geometry constants used by the top level.
package pos_dec_pkg;

  // Default number of positions (width of the frame mask).
  localparam int NPOS_DEF  = 8;
  // Default width of the saturating beat counter.
  localparam int CNT_W_DEF = 4;

  // Two-state frame FSM: collect beats, then present the finished frame.
  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_e;

endpackage : pos_dec_pkg

// File: rtl/pos_onehot_dec.sv
// Combinational binary-position to one-hot decoder.
module pos_onehot_dec #(
  parameter int NPOS  = 8,
  parameter int POS_W = $clog2(NPOS)
) (
  input  logic [POS_W-1:0] i_pos,
  output logic [NPOS-1:0]  o_onehot
);

  // One comparator per output bit; exactly one bit is high for any legal position.
  for (genvar gi = 0; gi < NPOS; gi++) begin : g_bit
    assign o_onehot[gi] = (i_pos == POS_W'(gi));
  end

endmodule : pos_onehot_dec

// File: rtl/pos_mask_decoder.sv
// Accumulates one-hot position beats into a per-frame mask with a saturating
// beat count and a repeated-position flag, then holds the finished frame
// until the consumer takes it. The next frame may start in the same cycle
// the previous one is handed off.
module pos_mask_decoder
  import pos_dec_pkg::*;
#(
  parameter int NPOS  = NPOS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$clog2(NPOS)-1:0] in_pos,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NPOS-1:0]         out_mask,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_dup
);

  localparam int POS_W = $clog2(NPOS);

  state_e           r_state;
  logic [NPOS-1:0]  r_acc_mask;
  logic [CNT_W-1:0] r_acc_count;
  logic             r_acc_dup;
  logic [NPOS-1:0]  r_out_mask;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_dup;

  logic [NPOS-1:0]  w_onehot;
  logic             w_beat;
  logic             w_frame;
  logic [NPOS-1:0]  w_new_mask;
  logic [CNT_W-1:0] w_new_count;
  logic             w_new_dup;

  pos_onehot_dec #(
    .NPOS  (NPOS),
    .POS_W (POS_W)
  ) u_dec (
    .i_pos    (in_pos),
    .o_onehot (w_onehot)
  );

  // In EMIT the block can only take a beat when the pending frame leaves
  // in the same cycle, so input readiness follows the consumer.
  assign in_ready  = (r_state == ST_ACCUM) ? 1'b1 : out_ready;
  assign out_valid = (r_state == ST_EMIT);
  assign out_mask  = r_out_mask;
  assign out_count = r_out_count;
  assign out_dup   = r_out_dup;

  assign w_beat  = in_valid && in_ready;
  assign w_frame = out_valid && out_ready;

  // The accumulator is always clear while in EMIT, so these "accumulator
  // plus this beat" values are correct in either state.
  assign w_new_mask  = r_acc_mask | w_onehot;
  assign w_new_dup   = r_acc_dup | (|(r_acc_mask & w_onehot));
  assign w_new_count = (&r_acc_count) ? r_acc_count : r_acc_count + CNT_W'(1);

  // Frame FSM, accumulator and output holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_acc_mask  <= '0;
      r_acc_count <= '0;
      r_acc_dup   <= 1'b0;
      r_out_mask  <= '0;
      r_out_count <= '0;
      r_out_dup   <= 1'b0;
    end else if (w_beat) begin
      if (in_last) begin
        // Frame closes: publish it and start the next one empty.
        r_out_mask  <= w_new_mask;
        r_out_count <= w_new_count;
        r_out_dup   <= w_new_dup;
        r_acc_mask  <= '0;
        r_acc_count <= '0;
        r_acc_dup   <= 1'b0;
        r_state     <= ST_EMIT;
      end else begin
        // Any beat taken in EMIT coincides with the frame handshake.
        r_acc_mask  <= w_new_mask;
        r_acc_count <= w_new_count;
        r_acc_dup   <= w_new_dup;
        r_state     <= ST_ACCUM;
      end
    end else if (w_frame) begin
      r_state <= ST_ACCUM;
    end
  end

endmodule : pos_mask_decoder

// File: tb/tb_pos_mask_decoder.sv
// Directed bench for pos_mask_decoder (NPOS=8, CNT_W=4): a frame table
// plus hand-written sequences for back-pressure, back-to-back and reset cases.
module tb_pos_mask_decoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_pos;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mask;
  logic [3:0] out_count;
  logic       out_dup;

  int n_total = 0;
  int n_pass  = 0;

  pos_mask_decoder #(
    .NPOS  (8),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pos    (in_pos),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_count (out_count),
    .out_dup   (out_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [11:0] pos;   // beat j position at pos[3*j +: 3]
    logic [7:0] mask;
    logic [3:0] cnt;
    logic       dup;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // One accepted beat; returns at 1 time unit after the accepting edge.
  task automatic beat(input logic [2:0] p, input logic l);
    in_valid = 1'b1;
    in_pos   = p;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string nm, input logic [7:0] m, input logic [3:0] c, input logic d);
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".mask"},  32'(out_mask),  32'(m));
    chk({nm, ".count"}, 32'(out_count), 32'(c));
    chk({nm, ".dup"},   32'(out_dup),   32'(d));
    $display("frame %s: mask=%08b count=%0d dup=%0d", nm, out_mask, out_count, out_dup);
  endtask

  initial begin
    vecs[0] = '{3, {3'd0, 3'd0, 3'd3, 3'd7}, 8'b1000_1001, 4'd3, 1'b0};
    vecs[1] = '{2, {3'd0, 3'd0, 3'd5, 3'd5}, 8'b0010_0000, 4'd2, 1'b1};
    vecs[2] = '{1, {3'd0, 3'd0, 3'd0, 3'd4}, 8'b0001_0000, 4'd1, 1'b0};
    vecs[3] = '{4, {3'd0, 3'd2, 3'd1, 3'd0}, 8'b0000_0111, 4'd4, 1'b1};
    vecs[4] = '{2, {3'd0, 3'd0, 3'd7, 3'd6}, 8'b1100_0000, 4'd2, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_pos = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    // Reset state
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.mask",  32'(out_mask),  32'd0);
    chk("rst.count", 32'(out_count), 32'd0);
    chk("rst.dup",   32'(out_dup),   32'd0);
    chk("rst.ready", 32'(in_ready),  32'd1);

    // Table of frames, consumer always ready
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        logic [2:0] p;
        p = vecs[i].pos[3*j +: 3];
        if (j == vecs[i].n - 1) chk($sformatf("v%0d.pre_valid", i), 32'(out_valid), 32'd0);
        beat(p, (j == vecs[i].n - 1));
      end
      chk_frame($sformatf("v%0d", i), vecs[i].mask, vecs[i].cnt, vecs[i].dup);
      idle(1);
      chk($sformatf("v%0d.drained", i), 32'(out_valid), 32'd0);
    end

    // Back-pressure in EMIT, then handshake with a simultaneous last beat
    beat(3'd1, 1'b0);
    beat(3'd2, 1'b1);
    chk_frame("bp.first", 8'b0000_0110, 4'd2, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_pos = 3'd2; in_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp.in_ready%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp.mask%0d", k),     32'(out_mask), 32'h06);
      chk($sformatf("bp.valid%0d", k),    32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_follow", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk_frame("bp.next", 8'b0000_0100, 4'd1, 1'b0);
    idle(1);
    chk("bp.drained", 32'(out_valid), 32'd0);

    // Handshake with a non-last beat: next frame starts with that beat only
    beat(3'd3, 1'b1);
    chk_frame("b2b.a", 8'b0000_1000, 4'd1, 1'b0);
    beat(3'd5, 1'b0);
    chk("b2b.accum", 32'(out_valid), 32'd0);
    beat(3'd5, 1'b1);
    chk_frame("b2b.b", 8'b0010_0000, 4'd2, 1'b1);
    idle(1);

    // Saturating count: 20 beats at position 1
    for (int k = 0; k < 20; k++) beat(3'd1, (k == 19));
    chk_frame("sat", 8'b0000_0010, 4'd15, 1'b1);
    idle(1);

    // Reset mid-frame discards the partial frame
    beat(3'd3, 1'b0);
    beat(3'd4, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.mask",  32'(out_mask),  32'd0);
    beat(3'd6, 1'b1);
    chk_frame("midrst", 8'b0100_0000, 4'd1, 1'b0);

    // Reset in EMIT drops the pending frame; it wins over the handshake
    out_ready = 1'b1;
    rst = 1'b1;
    in_valid = 1'b1; in_pos = 3'd0; in_last = 1'b1;
    idle(1);
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("emitrst.valid", 32'(out_valid), 32'd0);
    chk("emitrst.mask",  32'(out_mask),  32'd0);
    chk("emitrst.count", 32'(out_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pos_mask_decoder
